link_len_lut: RTL

LINK_LEN_LUT -- requirements
Module: link_len_lut

---
 rtl/sat_up_pkg.sv | 41 ++++
 rtl/link_len_lut_ram.sv | 27 ++
 rtl/link_len_lut.sv | 129 ++++++++++++
 3 files changed

// File: rtl/sat_up_pkg.sv
// Shared types and default link-length table.
// Holds the FSM encoding and the boot-time contents of the lookup table.
package sat_up_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int TBL_LEN_W = 13;
  localparam int TBL_DEPTH = 64;

  // Each entry is {vld, len}.
  typedef logic [TBL_LEN_W:0] tbl_ent_t;
  typedef tbl_ent_t [TBL_DEPTH-1:0] tbl_t;

  // IDs 3..34 carry a length; every other ID is invalid with len 0.
  function automatic tbl_t build_tbl();
    tbl_t t;
    t = '0;
    for (int k = 3; k <= 34; k++) begin
      t[k] = {1'b1, 13'(k * 192)};
    end
    t[3]  = {1'b1, 13'h000A};
    t[4]  = {1'b1, 13'h03C0};
    t[19] = {1'b1, 13'h15F0};
    t[34] = {1'b1, 13'h1040};
    return t;
  endfunction

  localparam tbl_t DEFAULT_TBL = build_tbl();

  // IDs beyond the stored table default to an invalid entry.
  function automatic tbl_ent_t default_entry(input int unsigned k);
    tbl_ent_t e;
    e = '0;
    if (k < TBL_DEPTH) e = DEFAULT_TBL[k];
    return e;
  endfunction

endpackage

// File: rtl/link_len_lut_ram.sv
// Link-length table storage.
// One write port, one registered read port; a read and write to the
// same address on one edge returns the old contents.
module len_tbl_ram #(
  parameter int AW = 6,
  parameter int DW = 14
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  // Write and registered read share the edge; NBA gives old data.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/link_len_lut.sv
// Link-ID to interleaver-length lookup.
// Table loads defaults after reset or soft_init, then serves lookups.
module link_len_lut
  import sat_up_pkg::*;
#(
  parameter int ID_W  = 6,
  parameter int LEN_W = 13,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             soft_init,
  output logic             init_busy,
  input  logic             req_valid,
  input  logic [ID_W-1:0]  req_id,
  output logic             req_ready,
  output logic             rsp_valid,
  output logic [LEN_W-1:0] rsp_len,
  output logic             rsp_err,
  input  logic             cfg_we,
  input  logic [ID_W-1:0]  cfg_addr,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_vld,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int DW = LEN_W + 1;
  localparam logic [ID_W-1:0]  K_LAST  = '1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state_q;
  logic [ID_W-1:0]   k_q;
  logic              s1_vld_q;
  logic              rsp_valid_q;
  logic [LEN_W-1:0]  rsp_len_q;
  logic              rsp_err_q;
  logic [CNT_W-1:0]  err_cnt_q;

  tbl_ent_t          def_ent;
  logic              wr_en;
  logic [ID_W-1:0]   wr_addr;
  logic [DW-1:0]     wr_data;
  logic [DW-1:0]     rd_data;
  logic              accept;

  assign init_busy = (state_q == ST_INIT);
  assign req_ready = ~init_busy;
  assign accept    = req_valid & req_ready;
  assign def_ent   = default_entry(32'(k_q));

  // Table load walks k through every address, then serves lookups.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_INIT;
      k_q     <= '0;
    end else begin
      case (state_q)
        ST_INIT: begin
          k_q <= k_q + 1'b1;
          if (k_q == K_LAST) state_q <= ST_RUN;
        end
        ST_RUN: begin
          if (soft_init) begin
            state_q <= ST_INIT;
            k_q     <= '0;
          end
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end

  // Loader owns the write port during INIT; cfg writes are dropped.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = cfg_addr;
    wr_data = {cfg_vld, cfg_len};
    if (init_busy) begin
      wr_en   = 1'b1;
      wr_addr = k_q;
      wr_data = {def_ent[TBL_LEN_W],
                 LEN_W'(def_ent[TBL_LEN_W-1:0])};
    end else begin
      wr_en   = cfg_we;
    end
  end

  len_tbl_ram #(
    .AW (ID_W),
    .DW (DW)
  ) u_len_tbl_ram (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (wr_addr),
    .wdata_i (wr_data),
    .raddr_i (req_id),
    .rdata_o (rd_data)
  );

  // Stage 1 tracks the table read; it survives a soft_init reload.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) s1_vld_q <= 1'b0;
    else        s1_vld_q <= accept;
  end

  // Stage 2 registers the response and counts invalid-ID hits.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rsp_valid_q <= 1'b0;
      rsp_len_q   <= '0;
      rsp_err_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      rsp_valid_q <= s1_vld_q;
      if (s1_vld_q) begin
        rsp_err_q <= ~rd_data[DW-1];
        rsp_len_q <= rd_data[DW-1] ? rd_data[LEN_W-1:0] : '0;
        if (!rd_data[DW-1] && err_cnt_q != CNT_MAX)
          err_cnt_q <= err_cnt_q + 1'b1;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_len   = rsp_len_q;
  assign rsp_err   = rsp_err_q;
  assign err_cnt   = err_cnt_q;

endmodule
